// File: rtl/detector_jogada_pkg.sv
// Shared constants, FSM state codes and button-vector helpers for the
// move detector that feeds the game control unit.
package detector_jogada_pkg;

   localparam int N_BOTOES = 9;
   localparam int W_JOGADA = 4;

   typedef enum logic [1:0] {
      ESPERA    = 2'd0,
      EMITE     = 2'd1,
      SOLTA     = 2'd2,
      NAO_USADO = 2'd3
   } estado_t;

   // True when exactly one button is down.
   function automatic logic um_quente(input logic [N_BOTOES-1:0] v);
      return (v != '0) && ((v & (v - N_BOTOES'(1))) == '0);
   endfunction

   function automatic logic [W_JOGADA-1:0] indice(input logic [N_BOTOES-1:0] v);
      logic [W_JOGADA-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_BOTOES; i++) begin
         idx = v[i] ? W_JOGADA'(i) : idx;
      end
      return idx;
   endfunction

endpackage

// File: rtl/detector_jogada_if.sv
// Board-button input bundle between the game controller and the move detector.
interface detector_jogada_if;
   import detector_jogada_pkg::*;

   logic                zera;
   logic                habilita;
   logic [N_BOTOES-1:0] botoes;
   logic                tem_jogada;
   logic [W_JOGADA-1:0] jogada;
   logic [N_BOTOES-1:0] db_botoes;
   logic                db_erro;
   logic [1:0]          db_estado;

   modport master (
      output zera, habilita, botoes,
      input  tem_jogada, jogada, db_botoes, db_erro, db_estado
   );

   modport slave (
      input  zera, habilita, botoes,
      output tem_jogada, jogada, db_botoes, db_erro, db_estado
   );

endinterface

// File: rtl/detector_jogada_debounce.sv
// One button: 2-FF synchronizer plus a stability counter that restarts on any
// bounce; the level only follows the input after DEBOUNCE_CICLOS steady cycles.
module debounce_botao #(
   parameter int DEBOUNCE_CICLOS = 50000
) (
   input  logic clock,
   input  logic reset,
   input  logic zera,
   input  logic bruto,
   output logic nivel,
   output logic ativo
);

   localparam int                W_CONT = $clog2(DEBOUNCE_CICLOS + 1);
   localparam logic [W_CONT-1:0] ULTIMO = W_CONT'(DEBOUNCE_CICLOS - 1);

   logic              sync_a;
   logic              sync_b;
   logic [W_CONT-1:0] cont;

   // Synchronizer, stability counter and accepted level.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
         cont   <= '0;
         nivel  <= 1'b0;
      end else if (zera) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
         cont   <= '0;
         nivel  <= 1'b0;
      end else begin
         sync_a <= bruto;
         sync_b <= sync_a;
         if (sync_b == nivel) begin
            cont <= '0;
         end else if (cont >= ULTIMO) begin
            nivel <= sync_b;
            cont  <= '0;
         end else begin
            cont <= cont + W_CONT'(1);
         end
      end
   end

   // Anything still in flight through the synchronizer or the accepted level.
   assign ativo = sync_a | sync_b | nivel;

endmodule

// File: rtl/detector_jogada.sv
// Input stage of the game controller: debounces the 9 board buttons and turns
// one clean single-button press per release cycle into a position code.
module detector_jogada
   import detector_jogada_pkg::*;
#(
   parameter int DEBOUNCE_CICLOS = 50000
) (
   input logic              clock,
   input logic              reset,
   detector_jogada_if.slave bus
);

   logic [N_BOTOES-1:0] d;
   logic [N_BOTOES-1:0] ativo;
   estado_t             estado;
   estado_t             estado_prox;
   logic                recem;
   logic                bloqueio;
   logic                liberado;
   logic                tem_jogada_reg;
   logic                tem_jogada_prox;
   logic                db_erro_reg;
   logic                db_erro_prox;
   logic [W_JOGADA-1:0] jogada_reg;
   logic [W_JOGADA-1:0] jogada_prox;

   genvar gi;
   generate
      for (gi = 0; gi < N_BOTOES; gi++) begin : g_botao
         debounce_botao #(
            .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
         ) u_debounce (
            .clock (clock),
            .reset (reset),
            .zera  (bus.zera),
            .bruto (bus.botoes[gi]),
            .nivel (d[gi]),
            .ativo (ativo[gi])
         );
      end
   endgenerate

   // After a clear, buttons already held must drain out of the synchronizers too.
   assign liberado = (d == '0) && !(bloqueio && (recem || (ativo != '0)));

   // State register and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado         <= SOLTA;
         recem          <= 1'b1;
         bloqueio       <= 1'b1;
         tem_jogada_reg <= 1'b0;
         db_erro_reg    <= 1'b0;
         jogada_reg     <= '0;
      end else if (bus.zera) begin
         estado         <= SOLTA;
         recem          <= 1'b1;
         bloqueio       <= 1'b1;
         tem_jogada_reg <= 1'b0;
         db_erro_reg    <= 1'b0;
         jogada_reg     <= '0;
      end else begin
         estado         <= estado_prox;
         recem          <= 1'b0;
         bloqueio       <= bloqueio && (estado_prox != ESPERA);
         tem_jogada_reg <= tem_jogada_prox;
         db_erro_reg    <= db_erro_prox;
         jogada_reg     <= jogada_prox;
      end
   end

   // Next-state logic.
   always_comb begin
      estado_prox = SOLTA;
      case (estado)
         ESPERA: begin
            if (d == '0) begin
               estado_prox = ESPERA;
            end else if (bus.habilita && um_quente(d)) begin
               estado_prox = EMITE;
            end else begin
               estado_prox = SOLTA;
            end
         end
         EMITE:   estado_prox = SOLTA;
         SOLTA: begin
            if (liberado) begin
               estado_prox = ESPERA;
            end else begin
               estado_prox = SOLTA;
            end
         end
         default: estado_prox = SOLTA;
      endcase
   end

   // Output values to be registered alongside the state.
   always_comb begin
      tem_jogada_prox = 1'b0;
      db_erro_prox    = 1'b0;
      jogada_prox     = jogada_reg;
      if ((estado == ESPERA) && (d != '0) && bus.habilita) begin
         if (um_quente(d)) begin
            tem_jogada_prox = 1'b1;
            jogada_prox     = indice(d);
         end else begin
            db_erro_prox = 1'b1;
         end
      end else begin
         tem_jogada_prox = 1'b0;
      end
   end

   assign bus.tem_jogada = tem_jogada_reg;
   assign bus.db_erro    = db_erro_reg;
   assign bus.jogada     = jogada_reg;
   assign bus.db_botoes  = d;
   assign bus.db_estado  = estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Scoreboard bench for detector_jogada: a behavioural model predicts strobes
// and held values, a monitor compares them against the DUT each cycle.
module tb_detector_jogada;
   import detector_jogada_pkg::*;

   localparam int N_DB = 4;

   typedef struct packed {
      logic        erro;
      logic [3:0]  jog;
      logic [31:0] ciclo;
   } evento_t;

   logic clock = 1'b0;
   logic reset;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   n_pulsos = 0;
   int   n_erros = 0;
   int   ultimo_pulso = -1;

   evento_t fila[$];

   // Behavioural model: debounced levels, raw history and capture readiness.
   logic [8:0] m_d;
   logic [8:0] m_p1;
   logic [8:0] m_p2;
   int         m_run[9];
   bit         m_pronto;
   bit         m_pula;
   bit         m_bloq;
   int         m_desde;
   int         m_jog;

   detector_jogada_if bus();

   detector_jogada #(.DEBOUNCE_CICLOS(N_DB)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic verifica(input string nome, input int obtido, input int esperado);
      total++;
      if (obtido != esperado) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nome, obtido, esperado, cyc);
      end
   endtask

   task automatic limpa_modelo();
      m_d = '0; m_p1 = '0; m_p2 = '0;
      for (int i = 0; i < 9; i++) m_run[i] = 0;
      m_pronto = 1'b0; m_pula = 1'b0; m_bloq = 1'b1; m_desde = 0; m_jog = 0;
   endtask

   // Advance the model across the coming clock edge using the inputs now applied.
   task automatic passo();
      logic [8:0] s2;
      int alvo;
      alvo = cyc + 1;
      if (reset || bus.zera) begin
         limpa_modelo();
      end else begin
         m_desde++;
         if (m_pronto) begin
            if (m_d != '0) begin
               m_pronto = 1'b0;
               if (bus.habilita && $countones(m_d) == 1) begin
                  m_jog = $clog2(m_d);
                  fila.push_back('{erro: 1'b0, jog: 4'(m_jog), ciclo: 32'(alvo)});
                  m_pula = 1'b1;
               end else if (bus.habilita) begin
                  fila.push_back('{erro: 1'b1, jog: 4'(m_jog), ciclo: 32'(alvo)});
               end
            end
         end else if (m_pula) begin
            m_pula = 1'b0;
         end else if (m_d == '0 && (!m_bloq || (m_desde >= 2 && m_p1 == '0 && m_p2 == '0))) begin
            m_pronto = 1'b1;
            m_bloq   = 1'b0;
         end
         s2 = m_p2;
         for (int i = 0; i < 9; i++) begin
            if (s2[i] != m_d[i]) begin
               m_run[i]++;
               if (m_run[i] == N_DB) begin
                  m_d[i]   = s2[i];
                  m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
         m_p2 = m_p1;
         m_p1 = bus.botoes;
      end
   endtask

   task automatic ciclo(input logic [8:0] b, input logic hab, input logic z);
      bus.botoes = b; bus.habilita = hab; bus.zera = z;
      passo();
      @(posedge clock); #3;
   endtask

   initial begin : monitor
      evento_t ev;
      forever begin
         @(posedge clock); #1;
         if (!reset) begin
            while (fila.size() > 0 && int'(fila[0].ciclo) < cyc) begin
               total++; bad++;
               ev = fila.pop_front();
               $display("FAIL evento_perdido: got nothing expected erro=%0b jog=%0d at cycle %0d", ev.erro, ev.jog, ev.ciclo);
            end
            if (bus.tem_jogada) begin n_pulsos++; ultimo_pulso = cyc; end
            if (bus.db_erro) n_erros++;
            if (bus.tem_jogada || bus.db_erro) begin
               total++;
               if (fila.size() == 0) begin
                  bad++;
                  $display("FAIL strobe_inesperado: got tem=%0b erro=%0b expected none (cycle %0d)", bus.tem_jogada, bus.db_erro, cyc);
               end else begin
                  ev = fila.pop_front();
                  if (int'(ev.ciclo) != cyc || ev.erro != bus.db_erro || bus.tem_jogada == ev.erro ||
                      (!ev.erro && bus.jogada != ev.jog)) begin
                     bad++;
                     $display("FAIL evento: got tem=%0b erro=%0b jog=%0d cycle %0d expected erro=%0b jog=%0d cycle %0d",
                              bus.tem_jogada, bus.db_erro, bus.jogada, cyc, ev.erro, ev.jog, ev.ciclo);
                  end
               end
            end
            verifica("jogada_mantida", int'(bus.jogada), m_jog);
            verifica("db_botoes", int'(bus.db_botoes), int'(m_d));
         end
      end
   end

   initial begin : driver
      int e;
      int p0;
      int er0;
      logic [8:0] b;
      logic hab;
      int dur;
      reset = 1'b1;
      bus.botoes = '0; bus.habilita = 1'b0; bus.zera = 1'b0;
      limpa_modelo();
      @(posedge clock); #3;
      verifica("reset_tem_jogada", int'(bus.tem_jogada), 0);
      verifica("reset_jogada", int'(bus.jogada), 0);
      verifica("reset_db_estado", int'(bus.db_estado), 2);
      verifica("reset_db_botoes", int'(bus.db_botoes), 0);
      verifica("reset_db_erro", int'(bus.db_erro), 0);
      reset = 1'b0;
      repeat (5) ciclo(9'd0, 1'b1, 1'b0);
      verifica("ocioso_espera", int'(bus.db_estado), 0);

      // Clean press of position 4.
      e = cyc; p0 = n_pulsos;
      repeat (20) ciclo(9'b000010000, 1'b1, 1'b0);
      verifica("latencia_pulso", ultimo_pulso, e + 7);
      verifica("jogada_4", int'(bus.jogada), 4);
      repeat (15) ciclo(9'd0, 1'b1, 1'b0);
      verifica("pulso_unico_4", n_pulsos - p0, 1);

      // Bouncing press and bouncing release of position 2.
      p0 = n_pulsos;
      for (int k = 0; k < 3; k++) begin
         repeat (2) ciclo(9'b000000100, 1'b1, 1'b0);
         repeat (2) ciclo(9'd0, 1'b1, 1'b0);
      end
      repeat (15) ciclo(9'b000000100, 1'b1, 1'b0);
      verifica("jogada_2", int'(bus.jogada), 2);
      for (int k = 0; k < 3; k++) begin
         repeat (2) ciclo(9'd0, 1'b1, 1'b0);
         repeat (2) ciclo(9'b000000100, 1'b1, 1'b0);
      end
      repeat (15) ciclo(9'd0, 1'b1, 1'b0);
      verifica("pulso_unico_bounce", n_pulsos - p0, 1);

      // Two buttons together are rejected, then position 8.
      p0 = n_pulsos; er0 = n_erros;
      repeat (20) ciclo(9'b000000101, 1'b1, 1'b0);
      verifica("erro_duplo", n_erros - er0, 1);
      verifica("sem_pulso_duplo", n_pulsos - p0, 0);
      verifica("jogada_inalterada", int'(bus.jogada), 2);
      repeat (15) ciclo(9'd0, 1'b1, 1'b0);
      repeat (20) ciclo(9'b100000000, 1'b1, 1'b0);
      verifica("jogada_8", int'(bus.jogada), 8);
      repeat (15) ciclo(9'd0, 1'b1, 1'b0);

      // Held while disabled, then enabled: ignored until re-pressed.
      p0 = n_pulsos;
      repeat (10) ciclo(9'b000001000, 1'b0, 1'b0);
      repeat (15) ciclo(9'b000001000, 1'b1, 1'b0);
      verifica("sem_pulso_habilita", n_pulsos - p0, 0);
      repeat (15) ciclo(9'd0, 1'b1, 1'b0);
      repeat (20) ciclo(9'b000001000, 1'b1, 1'b0);
      verifica("jogada_3", int'(bus.jogada), 3);
      repeat (15) ciclo(9'd0, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a debounce.
      repeat (4) ciclo(9'b000100000, 1'b1, 1'b0);
      reset = 1'b1; bus.botoes = '0;
      limpa_modelo();
      #1;
      verifica("rst_async_tem_jogada", int'(bus.tem_jogada), 0);
      verifica("rst_async_jogada", int'(bus.jogada), 0);
      verifica("rst_async_db_botoes", int'(bus.db_botoes), 0);
      verifica("rst_async_db_erro", int'(bus.db_erro), 0);
      verifica("rst_async_db_estado", int'(bus.db_estado), 2);
      @(posedge clock); #3;
      reset = 1'b0;
      repeat (8) ciclo(9'd0, 1'b1, 1'b0);

      // zera on the capture edge wins over the press.
      e = cyc; p0 = n_pulsos;
      repeat (6) ciclo(9'b000000010, 1'b1, 1'b0);
      ciclo(9'b000000010, 1'b1, 1'b1);
      verifica("zera_tem_jogada", int'(bus.tem_jogada), 0);
      verifica("zera_jogada", int'(bus.jogada), 0);
      verifica("zera_db_estado", int'(bus.db_estado), 2);
      repeat (10) ciclo(9'b000000010, 1'b1, 1'b0);
      repeat (15) ciclo(9'd0, 1'b1, 1'b0);
      verifica("zera_sem_pulso", n_pulsos - p0, 0);

      // Second button while the first is held is ignored.
      p0 = n_pulsos;
      repeat (10) ciclo(9'b000000001, 1'b1, 1'b0);
      repeat (15) ciclo(9'b010000001, 1'b1, 1'b0);
      repeat (15) ciclo(9'd0, 1'b1, 1'b0);
      verifica("segundo_ignorado_jogada", int'(bus.jogada), 0);
      verifica("segundo_ignorado_pulsos", n_pulsos - p0, 1);

      // Random presses, bounces, enables and clears.
      for (int r = 0; r < 60; r++) begin
         b = 9'(1 << $urandom_range(0, 8));
         if ($urandom_range(0, 9) == 0) b = b | 9'(1 << $urandom_range(0, 8));
         hab = ($urandom_range(0, 5) != 0);
         dur = $urandom_range(1, 14);
         for (int k = 0; k < dur; k++) begin
            ciclo(($urandom_range(0, 7) == 0) ? 9'd0 : b, hab, ($urandom_range(0, 60) == 0));
         end
         repeat ($urandom_range(1, 12)) ciclo(9'd0, hab, 1'b0);
      end
      repeat (20) ciclo(9'd0, 1'b1, 1'b0);
      verifica("fila_vazia", fila.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
